// File: rtl/imem_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// imem_fetch_sequencer
//
// Owns the program counter and issues one fetch per cycle to a
// synchronous-read instruction memory with one cycle of latency. Fetched
// words go to decode through a valid/ready output register. The block also
// handles backpressure (replay), redirect (flush) and halt.
//
// Ports
//   clock            single clock, all state updates on the rising edge
//   reset_n          asynchronous active-low reset
//   mem_address      instruction memory address (the pc register)
//   mem_q            memory data, holds M[address sampled at previous edge]
//   instr            fetched instruction (output register)
//   instr_pc         address of instr
//   instr_valid      instr / instr_pc valid
//   instr_ready      decode accepts when instr_valid && instr_ready
//   redirect         single-cycle request to restart fetch at redirect_target
//   redirect_target  new pc for a redirect
//   halt             level; while high no new fetches issue
//   halted           sequencer is in the HALTED state
//   accept_count     saturating count of completed handshakes
// ---------------------------------------------------------------------------
module imem_fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic              halted,
    output logic [CNT_W-1:0]  accept_count
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic                rsp_valid_reg;   // mem_q carries a live response
    logic [ADDR_W-1:0]   rsp_pc_reg;      // address of the word on mem_q
    logic [DATA_W-1:0]   instr_reg;
    logic [ADDR_W-1:0]   instr_pc_reg;
    logic                instr_valid_reg;
    logic [CNT_W-1:0]    accept_count_reg;

    logic blocked;
    logic handshake;
    logic issue;
    logic load;

    assign blocked   = instr_valid_reg && !instr_ready;
    assign handshake = instr_valid_reg && instr_ready;
    assign issue     = (state_reg == FETCH) && !blocked && !redirect && !halt;
    assign load      = rsp_valid_reg && !blocked && !redirect;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= FETCH;
            pc_reg           <= RESET_PC;
            rsp_valid_reg    <= 1'b0;
            rsp_pc_reg       <= '0;
            instr_reg        <= '0;
            instr_pc_reg     <= '0;
            instr_valid_reg  <= 1'b0;
            accept_count_reg <= '0;
        end else begin
            // A handshake counts even when a redirect flushes the output on
            // the same edge.
            if (handshake && (accept_count_reg != {CNT_W{1'b1}})) begin
                accept_count_reg <= accept_count_reg + CNT_ONE;
            end

            if (redirect) begin
                pc_reg          <= redirect_target;
                rsp_valid_reg   <= 1'b0;
                instr_valid_reg <= 1'b0;
                state_reg       <= halt ? HALTED : FETCH;
            end else begin
                rsp_valid_reg <= issue;
                if (issue) begin
                    rsp_pc_reg <= pc_reg;
                    pc_reg     <= pc_reg + ADDR_ONE;
                end

                // The output register is full, so the word arriving now has
                // nowhere to go: drop it and fetch it again once decode
                // frees the output. issue is low here, so no pc+1 conflict.
                if (rsp_valid_reg && blocked) begin
                    pc_reg <= rsp_pc_reg;
                end

                if (load) begin
                    instr_reg       <= mem_q;
                    instr_pc_reg    <= rsp_pc_reg;
                    instr_valid_reg <= 1'b1;
                end else if (handshake) begin
                    instr_valid_reg <= 1'b0;
                end

                case (state_reg)
                    FETCH:   if (halt)  state_reg <= HALTED;
                    HALTED:  if (!halt) state_reg <= FETCH;
                    default: state_reg <= FETCH;
                endcase
            end
        end
    end

    assign mem_address  = pc_reg;
    assign instr        = instr_reg;
    assign instr_pc     = instr_pc_reg;
    assign instr_valid  = instr_valid_reg;
    assign halted       = (state_reg == HALTED);
    assign accept_count = accept_count_reg;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
module tb_imem_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  mem_address;
    logic [31:0] mem_q;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_target = '0;
    logic        halt = 1'b0;
    logic        halted;
    logic [15:0] accept_count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] mem [256];

    imem_fetch_sequencer dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .mem_address     (mem_address),
        .mem_q           (mem_q),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted),
        .accept_count    (accept_count)
    );

    always #5 clock = ~clock;

    // Synchronous-read instruction memory: M[i] = 0x1000_0000 + i
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    end
    always @(posedge clock) mem_q <= mem[mem_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        instr_ready     = 1'b0;
        redirect        = 1'b0;
        halt            = 1'b0;
        redirect_target = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic push_range(input logic [7:0] first, input int n);
        logic [7:0] a;
        a = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 8'd1;
        end
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: a handshake completes at the next rising edge whenever
    // valid && ready are seen at the falling edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (reset_n && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept_pc", {24'h0, instr_pc}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("accept_pc", {24'h0, instr_pc}, {24'h0, e});
                    chk("accept_instr", instr, 32'h1000_0000 + {24'h0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset values, sequential fetch, backpressure
        reset_n = 1'b0;
        tick();
        chk("rst_mem_address", mem_address, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_accept_count", accept_count, 0);
        tick();
        reset_n = 1'b1;
        instr_ready = 1'b1;
        push_range(8'h00, 8);
        tick();                                  // edge 1: issue 0
        chk("e1_instr_valid", instr_valid, 0);
        chk("e1_mem_address", mem_address, 1);
        tick();                                  // edge 2: word 0 valid
        chk("e2_instr_valid", instr_valid, 1);
        chk("e2_instr_pc", instr_pc, 0);
        repeat (5) tick();                       // edges 3..7
        chk("e7_accept_count", accept_count, 5);
        chk("e7_instr_pc", instr_pc, 5);
        instr_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_instr_valid", instr_valid, 1);
            chk("bp_instr_pc", instr_pc, 5);
            chk("bp_instr", instr, 32'h1000_0005);
            chk("bp_mem_address", mem_address, 6);
        end
        instr_ready = 1'b1;
        tick();                                  // 5 accepted, bubble
        chk("bubble_instr_valid", instr_valid, 0);
        chk("bubble_accept_count", accept_count, 6);
        repeat (3) tick();
        instr_ready = 1'b0;
        chk("bp_done_pending", exp_q.size(), 0);
        chk("bp_accept_count", accept_count, 8);

        // ---------------- pc wrap from 0xFE
        do_reset();
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_target = 8'hFE;
        tick();
        redirect = 1'b0;
        chk("wrap_mem_address", mem_address, 8'hFE);
        push_range(8'hFE, 4);
        drain(20);
        instr_ready = 1'b0;

        // ---------------- redirect flush with word 4 valid, 5 in flight
        do_reset();
        instr_ready = 1'b1;
        push_range(8'h00, 4);
        repeat (6) tick();
        chk("rd_pre_instr_pc", instr_pc, 4);
        instr_ready = 1'b0;
        redirect = 1'b1;
        redirect_target = 8'h00;
        tick();                                  // edge E
        redirect = 1'b0;
        chk("rd_flush_valid", instr_valid, 0);
        chk("rd_mem_address", mem_address, 0);
        chk("rd_accept_count", accept_count, 4);
        push_range(8'h00, 2);
        instr_ready = 1'b1;
        tick();                                  // E+1
        chk("rd_e1_valid", instr_valid, 0);
        tick();                                  // E+2
        chk("rd_e2_valid", instr_valid, 1);
        chk("rd_e2_instr_pc", instr_pc, 0);
        drain(10);
        instr_ready = 1'b0;
        chk("rd_final_count", accept_count, 6);

        // ---------------- halt for 4 cycles, then halt + redirect
        do_reset();
        instr_ready = 1'b1;
        push_range(8'h00, 7);
        repeat (5) tick();
        halt = 1'b1;
        tick();
        chk("halt_halted", halted, 1);
        chk("halt_mem_address", mem_address, 5);
        chk("halt_inflight_pc", instr_pc, 4);
        chk("halt_inflight_valid", instr_valid, 1);
        repeat (3) begin
            tick();
            chk("halt_hold_halted", halted, 1);
            chk("halt_hold_address", mem_address, 5);
        end
        chk("halt_drained_valid", instr_valid, 0);
        halt = 1'b0;
        tick();
        chk("unhalt_halted", halted, 0);
        drain(20);
        instr_ready = 1'b0;
        halt = 1'b1;
        redirect = 1'b1;
        redirect_target = 8'h10;
        tick();
        redirect = 1'b0;
        chk("hr_halted", halted, 1);
        chk("hr_mem_address", mem_address, 8'h10);
        chk("hr_instr_valid", instr_valid, 0);
        tick();
        chk("hr_hold_address", mem_address, 8'h10);
        chk("hr_hold_halted", halted, 1);
        push_range(8'h10, 2);
        instr_ready = 1'b1;
        halt = 1'b0;
        drain(20);
        instr_ready = 1'b0;

        // ---------------- asynchronous reset mid-stream
        do_reset();
        instr_ready = 1'b1;
        push_range(8'h00, 3);
        repeat (5) tick();
        instr_ready = 1'b0;
        chk("ar_pre_valid", instr_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_instr_valid", instr_valid, 0);
        chk("ar_instr", instr, 0);
        chk("ar_instr_pc", instr_pc, 0);
        chk("ar_mem_address", mem_address, 0);
        chk("ar_accept_count", accept_count, 0);
        chk("ar_halted", halted, 0);
        tick();
        tick();
        reset_n = 1'b1;
        push_range(8'h00, 2);
        instr_ready = 1'b1;
        tick();
        tick();
        chk("ar_restart_valid", instr_valid, 1);
        chk("ar_restart_pc", instr_pc, 0);
        drain(20);
        instr_ready = 1'b0;

        tick();
        chk("final_pending", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
